sensor_monitor: RTL and testbench

Parametrised, registered successor to the team's combinational 4-sensor error detector. It samples an N-bit sensor vector and applies per-channel runtime enables. Fault rules are configurable: critical sensors fault alone, and an anchor sensor faults when paired with any sensor in a pair group. A fault must persist for DEBOUNCE consecutive samples before `error` asserts. The error is latched until software clears it, and the block also reports a snapshot of the faulting vector and a saturating fault-event count.

---
 rtl/sensor_monitor.sv | 115 +++++++++++
 tb/tb_sensor_monitor.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/sensor_monitor.sv
// ============================================================================
// Module   : sensor_monitor
// Brief    : Registered, debounced N-channel sensor fault monitor. Errors are
//            latched until cleared, with a fault snapshot and an event count.
// Revision : 1.0 - initial parametrised release
// ============================================================================
`default_nettype none

module sensor_monitor #(
    parameter int                     NUM_SENSORS = 4,
    parameter logic [NUM_SENSORS-1:0] CRIT_MASK   = 4'b0001,
    parameter int                     ANCHOR_IDX  = 1,
    parameter logic [NUM_SENSORS-1:0] PAIR_MASK   = 4'b1100,
    parameter int                     DEBOUNCE    = 3,
    parameter int                     CNT_W       = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_SENSORS-1:0] sensors,
    input  logic [NUM_SENSORS-1:0] sensor_en,
    input  logic                   clear,
    output logic                   error,
    output logic                   error_pending,
    output logic [NUM_SENSORS-1:0] fault_snapshot,
    output logic [CNT_W-1:0]       fault_count
);

    localparam int CNT_BITS = $clog2(DEBOUNCE + 1);

    localparam logic [1:0] c_OK      = 2'd0;
    localparam logic [1:0] c_PENDING = 2'd1;
    localparam logic [1:0] c_ERROR   = 2'd2;

    localparam logic [NUM_SENSORS-1:0] c_ANCHOR_BIT = NUM_SENSORS'(1) << ANCHOR_IDX;
    // The anchor never pairs with itself, even if PAIR_MASK names it.
    localparam logic [NUM_SENSORS-1:0] c_PAIR_ONLY  = PAIR_MASK & ~c_ANCHOR_BIT;
    localparam logic [CNT_BITS-1:0]    c_DEB_LAST   = CNT_BITS'(DEBOUNCE - 1);

    logic [1:0]             r_state;
    logic [CNT_BITS-1:0]    r_cnt;
    logic [NUM_SENSORS-1:0] r_sens_q;
    logic [NUM_SENSORS-1:0] r_snapshot;
    logic [CNT_W-1:0]       r_count;
    logic                   w_raw_fault;
    logic                   w_enter_error;

    assign w_raw_fault = (|(r_sens_q & CRIT_MASK)) |
                         (r_sens_q[ANCHOR_IDX] & (|(r_sens_q & c_PAIR_ONLY)));

    assign w_enter_error = w_raw_fault &&
                           (((r_state == c_OK) && (DEBOUNCE == 1)) ||
                            ((r_state == c_PENDING) && (r_cnt == c_DEB_LAST)));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_OK;
            r_cnt    <= '0;
            r_sens_q <= '0;
        end else begin
            r_sens_q <= sensors & sensor_en;
            case (r_state)
                c_OK: begin
                    if (w_raw_fault && (DEBOUNCE == 1)) begin
                        r_state <= c_ERROR;
                    end else if (w_raw_fault) begin
                        r_state <= c_PENDING;
                        r_cnt   <= CNT_BITS'(1);
                    end else begin
                        r_cnt   <= '0;
                    end
                end
                c_PENDING: begin
                    if (!w_raw_fault) begin
                        r_state <= c_OK;
                        r_cnt   <= '0;
                    end else if (r_cnt == c_DEB_LAST) begin
                        r_state <= c_ERROR;
                    end else begin
                        r_cnt   <= r_cnt + 1'b1;
                    end
                end
                c_ERROR: begin
                    if (clear && !w_raw_fault) begin
                        r_state <= c_OK;
                        r_cnt   <= '0;
                    end
                end
                default: begin
                    r_state <= c_OK;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_snapshot <= '0;
            r_count    <= '0;
        end else if (w_enter_error) begin
            r_snapshot <= r_sens_q;
            if (r_count != {CNT_W{1'b1}}) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    assign error          = (r_state == c_ERROR);
    assign error_pending  = (r_state == c_PENDING);
    assign fault_snapshot = r_snapshot;
    assign fault_count    = r_count;

endmodule

`default_nettype wire

// File: tb/tb_sensor_monitor.sv
// ============================================================================
// Module   : tb_sensor_monitor
// Brief    : Directed self-checking bench for sensor_monitor (default build
//            plus a DEBOUNCE=1 / CNT_W=2 build for count saturation).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sensor_monitor;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] sensors, sensor_en;
    logic       clear;
    logic       error, error_pending;
    logic [3:0] fault_snapshot;
    logic [7:0] fault_count;

    logic [3:0] s_sensors, s_sensor_en;
    logic       s_clear;
    logic       s_error, s_error_pending;
    logic [3:0] s_fault_snapshot;
    logic [1:0] s_fault_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sensor_monitor u_dut (
        .clk            (clk),
        .rst            (rst),
        .sensors        (sensors),
        .sensor_en      (sensor_en),
        .clear          (clear),
        .error          (error),
        .error_pending  (error_pending),
        .fault_snapshot (fault_snapshot),
        .fault_count    (fault_count)
    );

    sensor_monitor #(.DEBOUNCE(1), .CNT_W(2)) u_sat (
        .clk            (clk),
        .rst            (rst),
        .sensors        (s_sensors),
        .sensor_en      (s_sensor_en),
        .clear          (s_clear),
        .error          (s_error),
        .error_pending  (s_error_pending),
        .fault_snapshot (s_fault_snapshot),
        .fault_count    (s_fault_count)
    );

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_clear();
        sensors = 4'b0000;
        tick(2);
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(2);
        checks++; if (error !== 1'b0) begin failures++; $display("FAIL reset_error got=%0b exp=0", error); end
        checks++; if (error_pending !== 1'b0) begin failures++; $display("FAIL reset_pending got=%0b exp=0", error_pending); end
        checks++; if (fault_snapshot !== 4'h0) begin failures++; $display("FAIL reset_snapshot got=%0h exp=0", fault_snapshot); end
        checks++; if (fault_count !== 8'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", fault_count); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        sensors = 4'b0110;
        tick();  // E0
        checks++; if (error_pending !== 1'b0) begin failures++; $display("FAIL basic_e0_pending got=%0b exp=0", error_pending); end
        tick();  // E1
        checks++; if (error_pending !== 1'b1 || error !== 1'b0) begin failures++; $display("FAIL basic_e1 got pend=%0b err=%0b exp pend=1 err=0", error_pending, error); end
        tick();  // E2
        checks++; if (error !== 1'b0) begin failures++; $display("FAIL basic_e2_error got=%0b exp=0", error); end
        tick();  // E3
        checks++; if (error !== 1'b1 || error_pending !== 1'b0) begin failures++; $display("FAIL basic_e3 got err=%0b pend=%0b exp err=1 pend=0", error, error_pending); end
        checks++; if (fault_snapshot !== 4'b0110) begin failures++; $display("FAIL basic_snapshot got=%0b exp=0110", fault_snapshot); end
        checks++; if (fault_count !== 8'd1) begin failures++; $display("FAIL basic_count got=%0d exp=1", fault_count); end
        tick(6);
        checks++; if (error !== 1'b1 || fault_count !== 8'd1) begin failures++; $display("FAIL basic_hold got err=%0b cnt=%0d exp err=1 cnt=1", error, fault_count); end
        rst = 1'b1;
        sensors = 4'b0000;
        tick();
        checks++; if (error !== 1'b0 || error_pending !== 1'b0 || fault_snapshot !== 4'h0 || fault_count !== 8'd0)
            begin failures++; $display("FAIL midreset got err=%0b pend=%0b snap=%0h cnt=%0d exp all 0", error, error_pending, fault_snapshot, fault_count); end
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_glitch();
        int pend_cycles;
        pend_cycles = 0;
        sensors = 4'b0001;
        tick(2);
        if (error_pending) pend_cycles++;
        sensors = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (error_pending) pend_cycles++;
            if (error) pend_cycles = 99;
        end
        checks++; if (pend_cycles !== 2) begin failures++; $display("FAIL glitch_pending_len got=%0d exp=2", pend_cycles); end
        checks++; if (error !== 1'b0 || fault_count !== 8'd0) begin failures++; $display("FAIL glitch_noerr got err=%0b cnt=%0d exp err=0 cnt=0", error, fault_count); end
        sensors = 4'b0001;
        tick(3);
        sensors = 4'b0000;
        tick();
        checks++; if (error !== 1'b1 || fault_count !== 8'd1 || fault_snapshot !== 4'b0001)
            begin failures++; $display("FAIL glitch_3cyc got err=%0b cnt=%0d snap=%0b exp err=1 cnt=1 snap=0001", error, fault_count, fault_snapshot); end
        do_clear();
        checks++; if (error !== 1'b0) begin failures++; $display("FAIL glitch_clear got=%0b exp=0", error); end
    endtask

    task automatic test_legacy();
        logic [3:0] v;
        logic       exp_err;
        int         exp_cnt;
        exp_cnt = 1;
        for (int i = 0; i < 16; i++) begin
            v = 4'(i);
            exp_err = v[0] | (v[1] & v[3]) | (v[1] & v[2]);
            sensors = v;
            tick(5);
            if (exp_err) exp_cnt++;
            checks++; if (error !== exp_err) begin failures++; $display("FAIL legacy_err[%0b] got=%0b exp=%0b", v, error, exp_err); end
            checks++; if (fault_count !== 8'(exp_cnt)) begin failures++; $display("FAIL legacy_cnt[%0b] got=%0d exp=%0d", v, fault_count, exp_cnt); end
            if (exp_err) begin
                checks++; if (fault_snapshot !== v) begin failures++; $display("FAIL legacy_snap[%0b] got=%0b exp=%0b", v, fault_snapshot, v); end
            end
            do_clear();
            checks++; if (error !== 1'b0) begin failures++; $display("FAIL legacy_clear[%0b] got=%0b exp=0", v, error); end
        end
    endtask

    task automatic test_clear_rules();
        logic [7:0] cnt_before;
        sensors = 4'b0001;
        tick(5);
        cnt_before = fault_count;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        tick();
        checks++; if (error !== 1'b1) begin failures++; $display("FAIL clear_ignored got=%0b exp=1", error); end
        do_clear();
        checks++; if (error !== 1'b0 || error_pending !== 1'b0) begin failures++; $display("FAIL clear_ok got err=%0b pend=%0b exp 0 0", error, error_pending); end
        checks++; if (fault_count !== cnt_before || fault_snapshot !== 4'b0001)
            begin failures++; $display("FAIL clear_keeps got cnt=%0d snap=%0b exp cnt=%0d snap=0001", fault_count, fault_snapshot, cnt_before); end
    endtask

    task automatic test_enable();
        sensor_en = 4'b1110;
        sensors   = 4'b0001;
        tick(10);
        checks++; if (error !== 1'b0 || error_pending !== 1'b0) begin failures++; $display("FAIL en_masked got err=%0b pend=%0b exp 0 0", error, error_pending); end
        sensor_en = 4'b1111;
        tick(3);
        checks++; if (error !== 1'b0) begin failures++; $display("FAIL en_early got=%0b exp=0", error); end
        tick();
        checks++; if (error !== 1'b1) begin failures++; $display("FAIL en_error got=%0b exp=1", error); end
        do_clear();
        sensors = 4'b0001;
        tick(2);
        checks++; if (error_pending !== 1'b1) begin failures++; $display("FAIL en_pend_set got=%0b exp=1", error_pending); end
        sensor_en = 4'b1110;
        tick(2);
        checks++; if (error_pending !== 1'b0) begin failures++; $display("FAIL en_pend_drop got=%0b exp=0", error_pending); end
        tick(4);
        checks++; if (error !== 1'b0) begin failures++; $display("FAIL en_no_error got=%0b exp=0", error); end
        sensors   = 4'b0000;
        sensor_en = 4'b1111;
        tick();
    endtask

    task automatic test_saturation();
        logic [3:0] vecs [5];
        logic [1:0] exp_cnt [5];
        vecs    = '{4'b0001, 4'b0110, 4'b1010, 4'b0011, 4'b1011};
        exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        for (int i = 0; i < 5; i++) begin
            s_sensors = vecs[i];
            tick(2);
            checks++; if (s_error !== 1'b1) begin failures++; $display("FAIL sat_err[%0d] got=%0b exp=1", i, s_error); end
            checks++; if (s_fault_count !== exp_cnt[i]) begin failures++; $display("FAIL sat_cnt[%0d] got=%0d exp=%0d", i, s_fault_count, exp_cnt[i]); end
            checks++; if (s_fault_snapshot !== vecs[i]) begin failures++; $display("FAIL sat_snap[%0d] got=%0b exp=%0b", i, s_fault_snapshot, vecs[i]); end
            s_sensors = 4'b0000;
            tick(2);
            s_clear = 1'b1;
            tick();
            s_clear = 1'b0;
            checks++; if (s_error !== 1'b0) begin failures++; $display("FAIL sat_clear[%0d] got=%0b exp=0", i, s_error); end
        end
    endtask

    initial begin
        rst = 1'b1;
        sensors = 4'b0000;   sensor_en = 4'b1111;   clear = 1'b0;
        s_sensors = 4'b0000; s_sensor_en = 4'b1111; s_clear = 1'b0;
        test_reset();
        test_basic();
        test_glitch();
        test_legacy();
        test_clear_rules();
        test_enable();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
